// File: rtl/mem_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_write_arbiter_if
//
// Purpose: groups the two requester channels and the shared driver-memory
// write bus of mem_write_arbiter into one bundle.
//
// Signals:
//   write_window          backend idle, driver memories may be written
//   a_req / b_req         write requests (A = host command, B = pattern load)
//   a_driver / b_driver   target driver index (3 bits)
//   a_addr / b_addr       memory word address (7 bits)
//   a_data / b_data       write data (16 bits)
//   a_ack / b_ack         one-cycle completion pulse to the granted requester
//   mem_address           shared memory address
//   data_out              shared write data
//   mem_write_n           per-driver active-low write strobe
//   busy                  arbiter is inside a transaction
//   last_grant            0 = A granted last, 1 = B granted last
//   drv_err               pulse with ack when the driver index was out of range
//
// Modports:
//   master  requester / environment side
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface mem_write_arbiter_if #(
   parameter int NUM_OF_DRIVERS = 8
);

   logic                      write_window;
   logic                      a_req;
   logic                      b_req;
   logic [2:0]                a_driver;
   logic [2:0]                b_driver;
   logic [6:0]                a_addr;
   logic [6:0]                b_addr;
   logic [15:0]               a_data;
   logic [15:0]               b_data;
   logic                      a_ack;
   logic                      b_ack;
   logic [6:0]                mem_address;
   logic [15:0]               data_out;
   logic [NUM_OF_DRIVERS-1:0] mem_write_n;
   logic                      busy;
   logic                      last_grant;
   logic                      drv_err;

   modport master (
      output write_window,
      output a_req, b_req,
      output a_driver, b_driver,
      output a_addr, b_addr,
      output a_data, b_data,
      input  a_ack, b_ack,
      input  mem_address, data_out, mem_write_n,
      input  busy, last_grant, drv_err
   );

   modport slave (
      input  write_window,
      input  a_req, b_req,
      input  a_driver, b_driver,
      input  a_addr, b_addr,
      input  a_data, b_data,
      output a_ack, b_ack,
      output mem_address, data_out, mem_write_n,
      output busy, last_grant, drv_err
   );

endinterface

// File: rtl/mem_write_arbiter.sv
// ---------------------------------------------------------------------------
// mem_write_arbiter
//
// Purpose: arbitrates between two write requesters (A: host command path,
// B: pattern load engine) for a set of driver memories sharing one address
// and data bus. A transaction is granted only while write_window is high,
// then walks SETUP -> WRITE -> HOLD (one cycle each) and returns to IDLE.
// Simultaneous requests are resolved round-robin using last_grant.
//
// Ports:
//   clock        single clock
//   reset_n      asynchronous active-low reset
//   bus          mem_write_arbiter_if.slave (requester channels + memory bus)
//   write_count  16-bit saturating count of valid writes
//                (present only when MEM_WRITE_COUNT_EN is defined)
//
// Parameter:
//   NUM_OF_DRIVERS  number of driver memories / width of mem_write_n;
//                   must match the NUM_OF_DRIVERS of the connected interface.
//
// Optional feature macro: MEM_WRITE_COUNT_EN
// ---------------------------------------------------------------------------
module mem_write_arbiter #(
   parameter int NUM_OF_DRIVERS = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   mem_write_arbiter_if.slave bus
`ifdef MEM_WRITE_COUNT_EN
   ,
   output logic [15:0]        write_count
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      WRITE = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                    state;
   state_t                    next_state;

   // Arbitration result for the current cycle
   logic                      grant_en;
   logic                      grant_b;
   logic [2:0]                grant_driver;
   logic [6:0]                grant_addr;
   logic [15:0]               grant_data;

   // Payload captured at grant
   logic                      sel_b;
   logic [2:0]                lat_driver;
   logic [6:0]                lat_addr;
   logic [15:0]               lat_data;
   logic                      last_grant_q;
   logic                      driver_valid;

   // Registered outputs and their next values
   logic [NUM_OF_DRIVERS-1:0] strobe_q;
   logic [NUM_OF_DRIVERS-1:0] strobe_next;
   logic                      a_ack_q;
   logic                      b_ack_q;
   logic                      drv_err_q;
   logic                      busy_q;
   logic                      a_ack_next;
   logic                      b_ack_next;
   logic                      drv_err_next;
   logic                      busy_next;

   assign driver_valid = (int'(lat_driver) < NUM_OF_DRIVERS);

   // Next-state logic and arbitration. A grant is only possible from IDLE
   // with the window open; on a tie the requester that did not win last
   // time is chosen, so last_grant resetting to 1 lets A win the first tie.
   always_comb begin
      next_state   = state;
      grant_en     = 1'b0;
      grant_b      = 1'b0;
      grant_driver = 3'd0;
      grant_addr   = 7'd0;
      grant_data   = 16'd0;

      case (state)
         IDLE: begin
            if (bus.write_window && (bus.a_req || bus.b_req)) begin
               grant_en = 1'b1;
               if (bus.a_req && bus.b_req) begin
                  grant_b = ~last_grant_q;
               end else begin
                  grant_b = bus.b_req;
               end
               next_state = SETUP;
            end
         end
         SETUP:   next_state = WRITE;
         WRITE:   next_state = HOLD;
         HOLD:    next_state = IDLE;
         default: next_state = IDLE;
      endcase

      if (grant_b) begin
         grant_driver = bus.b_driver;
         grant_addr   = bus.b_addr;
         grant_data   = bus.b_data;
      end else begin
         grant_driver = bus.a_driver;
         grant_addr   = bus.a_addr;
         grant_data   = bus.a_data;
      end
   end

   // Output decode from the state being entered, so every output is a
   // flop and lines up with the state it belongs to. The strobe only fires
   // for an in-range driver index; out-of-range writes complete silently
   // apart from drv_err.
   always_comb begin
      strobe_next  = '1;
      a_ack_next   = 1'b0;
      b_ack_next   = 1'b0;
      drv_err_next = 1'b0;
      busy_next    = (next_state != IDLE);

      if (next_state == WRITE && driver_valid) begin
         for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
            if (int'(lat_driver) == i) begin
               strobe_next[i] = 1'b0;
            end
         end
      end

      if (next_state == HOLD) begin
         a_ack_next   = ~sel_b;
         b_ack_next   = sel_b;
         drv_err_next = ~driver_valid;
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Payload capture at grant. mem_address/data_out come straight from
   // these registers, which is what makes them hold their value in IDLE.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_b        <= 1'b0;
         lat_driver   <= 3'd0;
         lat_addr     <= 7'd0;
         lat_data     <= 16'd0;
         last_grant_q <= 1'b1;
      end else if (grant_en) begin
         sel_b        <= grant_b;
         lat_driver   <= grant_driver;
         lat_addr     <= grant_addr;
         lat_data     <= grant_data;
         last_grant_q <= grant_b;
      end
   end

   // Output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q  <= '1;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         drv_err_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         strobe_q  <= strobe_next;
         a_ack_q   <= a_ack_next;
         b_ack_q   <= b_ack_next;
         drv_err_q <= drv_err_next;
         busy_q    <= busy_next;
      end
   end

   assign bus.mem_address = lat_addr;
   assign bus.data_out    = lat_data;
   assign bus.mem_write_n = strobe_q;
   assign bus.a_ack       = a_ack_q;
   assign bus.b_ack       = b_ack_q;
   assign bus.drv_err     = drv_err_q;
   assign bus.busy        = busy_q;
   assign bus.last_grant  = last_grant_q;

`ifdef MEM_WRITE_COUNT_EN
   logic [15:0] count_q;

   // Counts each WRITE cycle that actually strobes a memory; sticks at max
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 16'd0;
      end else if (state == WRITE && driver_valid && count_q != 16'hFFFF) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign write_count = count_q;
`endif

endmodule

// File: tb/tb_mem_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_write_arbiter
//
// Purpose: self-checking bench for mem_write_arbiter. Two instances are
// used: dut8 (NUM_OF_DRIVERS = 8) and dut4 (NUM_OF_DRIVERS = 4, for the
// out-of-range driver case). Stimulus pushes hand-computed expected
// transactions into per-DUT queues; a negedge monitor pops and compares
// them whenever an ack appears, and tracks write strobes in between.
// Honours MEM_WRITE_COUNT_EN for the write_count port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_write_arbiter;

   logic clk = 1'b0;
   logic reset_n8;
   logic reset_n4;
   int   cyc = 0;
   int   check_count = 0;
   int   error_count = 0;

   always #5 clk = ~clk;

   // Cycle index: value k holds from just after one posedge to the next
   always @(posedge clk) cyc <= cyc + 1;

   mem_write_arbiter_if #(.NUM_OF_DRIVERS(8)) bus8 ();
   mem_write_arbiter_if #(.NUM_OF_DRIVERS(4)) bus4 ();

`ifdef MEM_WRITE_COUNT_EN
   logic [15:0] write_count8;
   logic [15:0] write_count4;
`endif

   mem_write_arbiter #(.NUM_OF_DRIVERS(8)) dut8 (
      .clock       (clk),
      .reset_n     (reset_n8),
      .bus         (bus8.slave)
`ifdef MEM_WRITE_COUNT_EN
      ,
      .write_count (write_count8)
`endif
   );

   mem_write_arbiter #(.NUM_OF_DRIVERS(4)) dut4 (
      .clock       (clk),
      .reset_n     (reset_n4),
      .bus         (bus4.slave)
`ifdef MEM_WRITE_COUNT_EN
      ,
      .write_count (write_count4)
`endif
   );

   typedef struct {
      logic        is_b;
      logic [6:0]  addr;
      logic [15:0] data;
      logic [7:0]  strobe;
      logic        err;
      int          ack_cyc;
   } exp_t;

   exp_t        q8[$];
   exp_t        q4[$];
   int          strobe_cnt[2];
   logic [7:0]  strobe_val[2];
   int          strobe_cyc[2];

   function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cyc);
      end
   endfunction

   function automatic void pushExpect(int d, logic is_b, logic [6:0] addr, logic [15:0] data,
                                      logic [7:0] strobe, logic err, int ack_cyc);
      exp_t e;
      e.is_b    = is_b;
      e.addr    = addr;
      e.data    = data;
      e.strobe  = strobe;
      e.err     = err;
      e.ack_cyc = ack_cyc;
      if (d == 0) q8.push_back(e);
      else        q4.push_back(e);
   endfunction

   // Monitor body for one DUT; strobe is widened to 8 bits with ones above
   function automatic void monitorSample(int d, logic a_ack, logic b_ack, logic [7:0] strobe,
                                         logic [6:0] addr, logic [15:0] data, logic err);
      exp_t  e;
      string tag;
      int    pending;
      logic [7:0] seen;
      tag     = (d == 0) ? "d8" : "d4";
      pending = (d == 0) ? q8.size() : q4.size();
      if (strobe != 8'hFF) begin
         if (pending == 0) checkOutput({tag, "_unexpected_strobe"}, 32'(strobe), 32'hFF);
         strobe_cnt[d]++;
         strobe_val[d] = strobe;
         strobe_cyc[d] = cyc;
      end
      if (a_ack || b_ack) begin
         if (pending == 0) begin
            checkOutput({tag, "_unexpected_ack"}, 32'({a_ack, b_ack}), 32'd0);
         end else begin
            if (d == 0) e = q8.pop_front();
            else        e = q4.pop_front();
            seen = (strobe_cnt[d] > 0) ? strobe_val[d] : 8'hFF;
            checkOutput({tag, "_ack_who"}, 32'({a_ack, b_ack}), 32'({~e.is_b, e.is_b}));
            checkOutput({tag, "_ack_cycle"}, 32'(cyc), 32'(e.ack_cyc));
            checkOutput({tag, "_mem_address"}, 32'(addr), 32'(e.addr));
            checkOutput({tag, "_data_out"}, 32'(data), 32'(e.data));
            checkOutput({tag, "_drv_err"}, 32'(err), 32'(e.err));
            checkOutput({tag, "_strobe_value"}, 32'(seen), 32'(e.strobe));
            checkOutput({tag, "_strobe_width"}, 32'(strobe_cnt[d]), (e.strobe != 8'hFF) ? 32'd1 : 32'd0);
            if (strobe_cnt[d] == 1) begin
               checkOutput({tag, "_strobe_cycle"}, 32'(strobe_cyc[d]), 32'(e.ack_cyc - 1));
            end
         end
         strobe_cnt[d] = 0;
         strobe_val[d] = 8'hFF;
      end else if (err) begin
         checkOutput({tag, "_stray_drv_err"}, 32'(err), 32'd0);
      end
   endfunction

   initial begin
      strobe_cnt[0] = 0;
      strobe_cnt[1] = 0;
      strobe_val[0] = 8'hFF;
      strobe_val[1] = 8'hFF;
      strobe_cyc[0] = 0;
      strobe_cyc[1] = 0;
   end

   always @(negedge clk) begin
      monitorSample(0, bus8.a_ack, bus8.b_ack, bus8.mem_write_n,
                    bus8.mem_address, bus8.data_out, bus8.drv_err);
      monitorSample(1, bus4.a_ack, bus4.b_ack, {4'hF, bus4.mem_write_n},
                    bus4.mem_address, bus4.data_out, bus4.drv_err);
   end

   task automatic nextCycle(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(int d, logic is_b, logic req, logic [2:0] drv,
                                logic [6:0] addr, logic [15:0] data);
      if (d == 0) begin
         if (is_b) begin
            bus8.b_req = req; bus8.b_driver = drv; bus8.b_addr = addr; bus8.b_data = data;
         end else begin
            bus8.a_req = req; bus8.a_driver = drv; bus8.a_addr = addr; bus8.a_data = data;
         end
      end else begin
         if (is_b) begin
            bus4.b_req = req; bus4.b_driver = drv; bus4.b_addr = addr; bus4.b_data = data;
         end else begin
            bus4.a_req = req; bus4.a_driver = drv; bus4.a_addr = addr; bus4.a_data = data;
         end
      end
   endtask

   task automatic checkResetValues(int d, string tag);
      if (d == 0) begin
         checkOutput({tag, "_rst_mem_write_n"}, 32'(bus8.mem_write_n), 32'hFF);
         checkOutput({tag, "_rst_mem_address"}, 32'(bus8.mem_address), 32'd0);
         checkOutput({tag, "_rst_data_out"}, 32'(bus8.data_out), 32'd0);
         checkOutput({tag, "_rst_acks"}, 32'({bus8.a_ack, bus8.b_ack}), 32'd0);
         checkOutput({tag, "_rst_drv_err"}, 32'(bus8.drv_err), 32'd0);
         checkOutput({tag, "_rst_busy"}, 32'(bus8.busy), 32'd0);
         checkOutput({tag, "_rst_last_grant"}, 32'(bus8.last_grant), 32'd1);
`ifdef MEM_WRITE_COUNT_EN
         checkOutput({tag, "_rst_write_count"}, 32'(write_count8), 32'd0);
`endif
      end else begin
         checkOutput({tag, "_rst_mem_write_n"}, 32'(bus4.mem_write_n), 32'hF);
         checkOutput({tag, "_rst_mem_address"}, 32'(bus4.mem_address), 32'd0);
         checkOutput({tag, "_rst_data_out"}, 32'(bus4.data_out), 32'd0);
         checkOutput({tag, "_rst_acks"}, 32'({bus4.a_ack, bus4.b_ack}), 32'd0);
         checkOutput({tag, "_rst_drv_err"}, 32'(bus4.drv_err), 32'd0);
         checkOutput({tag, "_rst_busy"}, 32'(bus4.busy), 32'd0);
         checkOutput({tag, "_rst_last_grant"}, 32'(bus4.last_grant), 32'd1);
`ifdef MEM_WRITE_COUNT_EN
         checkOutput({tag, "_rst_write_count"}, 32'(write_count4), 32'd0);
`endif
      end
   endtask

   // Hard stop in case something blocks forever
   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k;
      reset_n8 = 1'b0;
      reset_n4 = 1'b0;
      bus8.write_window = 1'b0;
      bus4.write_window = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 3'd0, 7'd0, 16'd0);
      applyStimulus(0, 1'b1, 1'b0, 3'd0, 7'd0, 16'd0);
      applyStimulus(1, 1'b0, 1'b0, 3'd0, 7'd0, 16'd0);
      applyStimulus(1, 1'b1, 1'b0, 3'd0, 7'd0, 16'd0);

      nextCycle(2);
      checkResetValues(0, "d8_init");
      checkResetValues(1, "d4_init");
      reset_n8 = 1'b1;
      reset_n4 = 1'b1;
      nextCycle(2);

      // Single A write to driver 2: strobe 8'hFB two cycles after grant, ack one later
      k = cyc;
      bus8.write_window = 1'b1;
      applyStimulus(0, 1'b0, 1'b1, 3'd2, 7'h15, 16'hBEEF);
      pushExpect(0, 1'b0, 7'h15, 16'hBEEF, 8'hFB, 1'b0, k + 3);
      nextCycle(1);
      checkOutput("t1_busy_setup", 32'(bus8.busy), 32'd1);
      checkOutput("t1_last_grant", 32'(bus8.last_grant), 32'd0);
      nextCycle(2);
      applyStimulus(0, 1'b0, 1'b0, 3'd2, 7'h15, 16'hBEEF);
      nextCycle(2);
      checkOutput("t1_addr_retained", 32'(bus8.mem_address), 32'h15);
      checkOutput("t1_data_retained", 32'(bus8.data_out), 32'hBEEF);

      // Reset restores last_grant to B so A wins the first tie
      reset_n8 = 1'b0;
      nextCycle(1);
      checkResetValues(0, "d8_mid");
      reset_n8 = 1'b1;
      nextCycle(1);

      // Both requesting continuously: A, B, A, B at 4-cycle spacing
      k = cyc;
      applyStimulus(0, 1'b0, 1'b1, 3'd0, 7'h01, 16'h1111);
      applyStimulus(0, 1'b1, 1'b1, 3'd5, 7'h02, 16'h2222);
      pushExpect(0, 1'b0, 7'h01, 16'h1111, 8'hFE, 1'b0, k + 3);
      pushExpect(0, 1'b1, 7'h02, 16'h2222, 8'hDF, 1'b0, k + 7);
      pushExpect(0, 1'b0, 7'h03, 16'h3333, 8'hFD, 1'b0, k + 11);
      pushExpect(0, 1'b1, 7'h04, 16'h4444, 8'h7F, 1'b0, k + 15);
      nextCycle(3);
      applyStimulus(0, 1'b0, 1'b1, 3'd1, 7'h03, 16'h3333);
      nextCycle(4);
      checkOutput("t2_last_grant_b", 32'(bus8.last_grant), 32'd1);
      applyStimulus(0, 1'b1, 1'b1, 3'd7, 7'h04, 16'h4444);
      nextCycle(8);
      applyStimulus(0, 1'b0, 1'b0, 3'd1, 7'h03, 16'h3333);
      applyStimulus(0, 1'b1, 1'b0, 3'd7, 7'h04, 16'h4444);
      nextCycle(2);

      // Window closed: B must wait, then complete 3 cycles after the window opens
      k = cyc;
      bus8.write_window = 1'b0;
      applyStimulus(0, 1'b1, 1'b1, 3'd3, 7'h7F, 16'hA5A5);
      for (int i = 0; i < 10; i++) begin
         checkOutput("t3_busy_window_low", 32'(bus8.busy), 32'd0);
         nextCycle(1);
      end
      bus8.write_window = 1'b1;
      pushExpect(0, 1'b1, 7'h7F, 16'hA5A5, 8'hF7, 1'b0, k + 13);
      nextCycle(3);
      applyStimulus(0, 1'b1, 1'b0, 3'd3, 7'h7F, 16'hA5A5);
      nextCycle(2);
      checkOutput("t3_last_grant", 32'(bus8.last_grant), 32'd1);

      // Req drops after grant and window drops during WRITE: still completes
      k = cyc;
      applyStimulus(0, 1'b0, 1'b1, 3'd6, 7'h2A, 16'h0F0F);
      pushExpect(0, 1'b0, 7'h2A, 16'h0F0F, 8'hBF, 1'b0, k + 3);
      nextCycle(1);
      applyStimulus(0, 1'b0, 1'b0, 3'd6, 7'h2A, 16'h0F0F);
      nextCycle(1);
      bus8.write_window = 1'b0;
      nextCycle(3);
      checkOutput("t4_last_grant", 32'(bus8.last_grant), 32'd0);
      checkOutput("t4_busy_done", 32'(bus8.busy), 32'd0);
      bus8.write_window = 1'b1;

      // dut4: driver 7 out of range -> no strobe, ack + drv_err
      k = cyc;
      bus4.write_window = 1'b1;
      applyStimulus(1, 1'b0, 1'b1, 3'd7, 7'h11, 16'hCAFE);
      pushExpect(1, 1'b0, 7'h11, 16'hCAFE, 8'hFF, 1'b1, k + 3);
      nextCycle(3);
      applyStimulus(1, 1'b0, 1'b0, 3'd7, 7'h11, 16'hCAFE);
      nextCycle(2);
`ifdef MEM_WRITE_COUNT_EN
      checkOutput("t5_write_count", 32'(write_count4), 32'd0);
`endif

      // dut4: valid driver 3 on B
      k = cyc;
      applyStimulus(1, 1'b1, 1'b1, 3'd3, 7'h22, 16'h1234);
      pushExpect(1, 1'b1, 7'h22, 16'h1234, 8'hF7, 1'b0, k + 3);
      nextCycle(3);
      applyStimulus(1, 1'b1, 1'b0, 3'd3, 7'h22, 16'h1234);
      nextCycle(2);
`ifdef MEM_WRITE_COUNT_EN
      checkOutput("t6_write_count", 32'(write_count4), 32'd1);
`endif

      // dut4: reset asserted in SETUP aborts the write; no strobe, no ack
      applyStimulus(1, 1'b0, 1'b1, 3'd1, 7'h33, 16'h5555);
      nextCycle(1);
      checkOutput("t7_busy_setup", 32'(bus4.busy), 32'd1);
      reset_n4 = 1'b0;
      applyStimulus(1, 1'b0, 1'b0, 3'd1, 7'h33, 16'h5555);
      #1;
      checkResetValues(1, "d4_abort");
      nextCycle(2);
      reset_n4 = 1'b1;
      nextCycle(6);
      checkOutput("t7_busy_after", 32'(bus4.busy), 32'd0);

      for (int i = 0; i < 50 && (q8.size() != 0 || q4.size() != 0); i++) begin
         nextCycle(1);
      end
      checkOutput("d8_queue_drained", 32'(q8.size()), 32'd0);
      checkOutput("d4_queue_drained", 32'(q4.size()), 32'd0);
`ifdef MEM_WRITE_COUNT_EN
      checkOutput("d8_write_count", 32'(write_count8), 32'd6);
`endif

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
